aclk_alarm_ctrl: RTL and testbench
==================================

Name: aclk_alarm_ctrl

Overview:
Alarm sequencing controller for the alarm clock. It compares current time against the programmed alarm time and drives the Alarm output. It also handles STOP_al, a snooze request with a bounded retry count, and auto-silence after a ring timeout. It sits between the timekeeping counters and the alarm output pin, and is clocked from the 10 Hz system clock.

Parameters:
CLK_PER_SEC, 10, clk cycles per real-time second (prescaler modulus)
SNOOZE_SEC, 300, seconds spent in SNOOZE before re-ringing
RING_TIMEOUT_SEC, 60, seconds of continuous ringing before auto-silence
MAX_SNOOZE, 3, maximum snoozes per alarm event
TW, 9, width of internal seconds timer (must hold max(SNOOZE_SEC, RING_TIMEOUT_SEC))

Ports:
clk  in  1  10 Hz system clock
reset  in  1  synchronous, active-high reset
AL_ON  in  1  alarm function enable
STOP_al  in  1  stop request; level-sampled each clk
SNOOZE  in  1  snooze request; level-sampled each clk
H_in  in  5  current hours, 0..23
M_in  in  6  current minutes, 0..59
H_al  in  5  alarm hours, 0..23
M_al  in  6  alarm minutes, 0..59
Alarm  out  1  high while ringing
snooze_active  out  1  high while in SNOOZE
snooze_cnt  out  2  snoozes used in the current alarm event
state_o  out  2  FSM state: IDLE=0, ARMED=1, RINGING=2, SNOOZE=3

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: state IDLE, Alarm=0, snooze_active=0, snooze_cnt=0, prescaler=0, seconds timer=0, match_q=0.
- Prescaler:
  - Free-running 0..CLK_PER_SEC-1.
  - sec_tick=1 in the cycle the prescaler equals CLK_PER_SEC-1.
  - The prescaler is never cleared except by reset.
- Match detection:
  - match = (H_in==H_al) && (M_in==M_al).
  - match_q is the registered match, updated every cycle in every state.
  - trigger = match && !match_q.
  - Enabling AL_ON mid-minute during a matching minute therefore does not ring.
- Seconds timer:
  - Cleared to 0 on every state transition.
  - Otherwise increments on sec_tick; saturates at its maximum value.
- All outputs are registered. Alarm and snooze_active reflect the new state 1 cycle after the deciding input is sampled.
- IDLE: AL_ON=1 -> ARMED.
- ARMED:
  - AL_ON=0 -> IDLE.
  - Otherwise trigger=1 -> RINGING, with snooze_cnt=0.
- RINGING (Alarm=1). Transition priority, highest first:
  1. AL_ON=0 -> IDLE.
  2. STOP_al=1 -> ARMED, snooze_cnt cleared to 0.
  3. SNOOZE=1 and snooze_cnt<MAX_SNOOZE -> SNOOZE, snooze_cnt+1.
  4. SNOOZE=1 and snooze_cnt==MAX_SNOOZE: the request is ignored and ringing continues.
  5. sec_tick=1 and timer==RING_TIMEOUT_SEC-1 -> ARMED, snooze_cnt cleared.
- SNOOZE (snooze_active=1, Alarm=0). Transition priority, highest first:
  1. AL_ON=0 -> IDLE.
  2. STOP_al=1 -> ARMED, snooze_cnt cleared.
  3. sec_tick=1 and timer==SNOOZE_SEC-1 -> RINGING; the ring timer restarts from 0.
  4. SNOOZE input is ignored in this state.
- Entering IDLE from any state clears snooze_cnt.
- Holding SNOOZE high across RINGING->SNOOZE->RINGING does not consume a second snooze until the level is sampled again in RINGING. Level semantics are intended; there is no edge detection on SNOOZE or STOP_al.
- STOP_al held high while in ARMED has no effect. A trigger in that cycle still enters RINGING, and STOP_al then returns the FSM to ARMED on the next cycle.
- Changes to H_al/M_al while in RINGING or SNOOZE do not affect the current event.
- Midnight wrap of H_in/M_in needs no special handling; matching is pure equality.
- Reset asserted mid-ring or mid-snooze: next cycle all outputs are at their reset values, regardless of other inputs.

Test Plan:
Use CLK_PER_SEC=10, SNOOZE_SEC=5, RING_TIMEOUT_SEC=8, MAX_SNOOZE=2.
1. Arm and ring: AL_ON=1, H_al=7, M_al=30, time steps 07:29 -> 07:30 -> Alarm=1 exactly 1 cycle after the minute change; state_o=2.
2. Stop: while ringing, STOP_al=1 for 1 cycle -> Alarm=0 next cycle, state_o=1. Time stays 07:30: no re-ring during the rest of the minute.
3. Snooze cycle: ring, SNOOZE pulse -> snooze_active=1, snooze_cnt=1. Alarm re-asserts after 5 s (50 clk, ±10 for prescaler phase). A second snooze gives snooze_cnt=2. A third SNOOZE is ignored: Alarm stays 1.
4. Timeout: ring with no input -> Alarm drops after 8 s (80 clk ±10); state_o=1; snooze_cnt=0.
5. Late enable and disable: AL_ON raised during 07:30 -> no ring. AL_ON=0 while ringing -> Alarm=0 and state_o=0 next cycle.
6. Reset mid-snooze: assert reset for 1 cycle in SNOOZE with snooze_cnt=1 -> all outputs 0 next cycle. A match occurring with AL_ON=1 after reset rings normally.

Source files
------------

// File: rtl/aclk_alarm_ctrl.sv
// aclk_alarm_ctrl: alarm sequencing controller for the 10 Hz alarm clock.
// Compares the current time with the programmed alarm time. It rings the Alarm output
// on the first cycle of a matching minute. It also handles stop, a bounded number of
// snoozes, and auto-silence after a ring timeout.
//
// Ports:
//   clk, reset      10 Hz clock, synchronous active-high reset
//   AL_ON           alarm function enable
//   STOP_al         stop request (level)
//   SNOOZE          snooze request (level)
//   H_in, M_in      current hours / minutes
//   H_al, M_al      alarm hours / minutes
//   Alarm           high while ringing (registered)
//   snooze_active   high while snoozing (registered)
//   snooze_cnt      snoozes used in the current alarm event
//   state_o         IDLE=0, ARMED=1, RINGING=2, SNOOZE=3
module aclk_alarm_ctrl #(
    parameter int unsigned CLK_PER_SEC      = 10,
    parameter int unsigned SNOOZE_SEC       = 300,
    parameter int unsigned RING_TIMEOUT_SEC = 60,
    parameter int unsigned MAX_SNOOZE       = 3,
    parameter int unsigned TW               = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       AL_ON,
    input  logic       STOP_al,
    input  logic       SNOOZE,
    input  logic [4:0] H_in,
    input  logic [5:0] M_in,
    input  logic [4:0] H_al,
    input  logic [5:0] M_al,
    output logic       Alarm,
    output logic       snooze_active,
    output logic [1:0] snooze_cnt,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StRinging = 2'd2,
        StSnooze  = 2'd3
    } state_e;

    localparam int unsigned   PW          = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_PER_SEC - 1);
    localparam logic [TW-1:0] RING_LAST   = TW'(RING_TIMEOUT_SEC - 1);
    localparam logic [TW-1:0] SNOOZE_LAST = TW'(SNOOZE_SEC - 1);
    localparam logic [TW-1:0] TIMER_MAX   = '1;
    localparam logic [1:0]    CNT_MAX     = 2'(MAX_SNOOZE);

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q;
    logic [TW-1:0]   timer_q;
    logic            match_q;
    logic [1:0]      cnt_d;
    logic            sec_tick;
    logic            match;
    logic            trigger;

    assign sec_tick = (presc_q == PRESC_LAST);
    assign match    = (H_in == H_al) && (M_in == M_al);
    // Rising edge of the match: only the first cycle of the alarm minute triggers, so
    // enabling mid-minute or returning to ARMED within the minute never re-rings.
    assign trigger  = match && !match_q;
    assign state_o  = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = snooze_cnt;
        case (state_q)
            StIdle: begin
                if (AL_ON) state_d = StArmed;
            end
            StArmed: begin
                if (!AL_ON) begin
                    state_d = StIdle;
                end else if (trigger) begin
                    state_d = StRinging;
                    cnt_d   = '0;
                end
            end
            StRinging: begin
                if (!AL_ON) begin
                    state_d = StIdle;
                end else if (STOP_al) begin
                    state_d = StArmed;
                    cnt_d   = '0;
                end else if (SNOOZE) begin
                    // At the snooze limit the request is swallowed and ringing continues.
                    if (snooze_cnt < CNT_MAX) begin
                        state_d = StSnooze;
                        cnt_d   = snooze_cnt + 2'd1;
                    end
                end else if (sec_tick && timer_q == RING_LAST) begin
                    state_d = StArmed;
                    cnt_d   = '0;
                end
            end
            StSnooze: begin
                if (!AL_ON) begin
                    state_d = StIdle;
                end else if (STOP_al) begin
                    state_d = StArmed;
                    cnt_d   = '0;
                end else if (sec_tick && timer_q == SNOOZE_LAST) begin
                    state_d = StRinging;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StIdle) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            presc_q       <= '0;
            timer_q       <= '0;
            match_q       <= 1'b0;
            snooze_cnt    <= '0;
            Alarm         <= 1'b0;
            snooze_active <= 1'b0;
        end else begin
            presc_q       <= sec_tick ? '0 : presc_q + PW'(1);
            match_q       <= match;
            state_q       <= state_d;
            snooze_cnt    <= cnt_d;
            Alarm         <= (state_d == StRinging);
            snooze_active <= (state_d == StSnooze);
            // Each state starts its own time budget from zero.
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (sec_tick && timer_q != TIMER_MAX) begin
                timer_q <= timer_q + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_aclk_alarm_ctrl.sv
// Scoreboard bench for aclk_alarm_ctrl. Stimulus pushes expected output snapshots tagged
// with the cycle at which they must hold; a monitor on the falling edge pops and compares.
module tb_aclk_alarm_ctrl;

    typedef struct {
        int         cyc;
        string      name;
        logic       alarm;
        logic       snz;
        logic [1:0] cnt;
        logic [1:0] st;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       AL_ON;
    logic       STOP_al;
    logic       SNOOZE;
    logic [4:0] H_in;
    logic [5:0] M_in;
    logic [4:0] H_al;
    logic [5:0] M_al;
    logic       Alarm;
    logic       snooze_active;
    logic [1:0] snooze_cnt;
    logic [1:0] state_o;

    exp_t sb[$];
    exp_t e;
    int   cyc     = 0;
    int   rst_cyc = 0;
    int   checks  = 0;
    int   errors  = 0;

    aclk_alarm_ctrl #(
        .CLK_PER_SEC     (10),
        .SNOOZE_SEC      (5),
        .RING_TIMEOUT_SEC(8),
        .MAX_SNOOZE      (2),
        .TW              (9)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .AL_ON        (AL_ON),
        .STOP_al      (STOP_al),
        .SNOOZE       (SNOOZE),
        .H_in         (H_in),
        .M_in         (M_in),
        .H_al         (H_al),
        .M_al         (M_al),
        .Alarm        (Alarm),
        .snooze_active(snooze_active),
        .snooze_cnt   (snooze_cnt),
        .state_o      (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Monitor
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || Alarm !== e.alarm || snooze_active !== e.snz ||
                snooze_cnt !== e.cnt || state_o !== e.st) begin
                errors++;
                $display("FAIL %s @cyc %0d: got Alarm=%b snz=%b cnt=%0d st=%0d, want cyc=%0d Alarm=%b snz=%b cnt=%0d st=%0d",
                         e.name, cyc, Alarm, snooze_active, snooze_cnt, state_o,
                         e.cyc, e.alarm, e.snz, e.cnt, e.st);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input string n, input logic a, input logic s,
                             input logic [1:0] cn, input logic [1:0] st);
        exp_t x;
        x.cyc = c; x.name = n; x.alarm = a; x.snz = s; x.cnt = cn; x.st = st;
        sb.push_back(x);
    endtask

    // Expectation for the state produced by the coming clock edge.
    task automatic expect_next(input string n, input logic a, input logic s,
                               input logic [1:0] cn, input logic [1:0] st);
        expect_at(cyc + 1, n, a, s, cn, st);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    // Prescaler model: state cycle c carries prescaler value (c - rst_cyc) % 10. Returns the
    // first state cycle after the n-th second tick seen from state cycle s onward.
    function automatic int tick_edge(input int s, input int n);
        int k = 0;
        for (int c = s; c < s + 1000; c++) begin
            if ((c - rst_cyc) % 10 == 9) k++;
            if (k == n) return c + 1;
        end
        return s + 1000;
    endfunction

    initial begin
        int s_cyc;
        int x_cyc;
        reset = 1'b1; AL_ON = 1'b0; STOP_al = 1'b0; SNOOZE = 1'b0;
        H_in = 5'd7; M_in = 6'd29; H_al = 5'd7; M_al = 6'd30;
        step();
        rst_cyc = cyc;
        expect_at(cyc, "reset", 1'b0, 1'b0, 2'd0, 2'd0);
        reset = 1'b0;
        step();

        // Arm and ring on minute change
        AL_ON = 1'b1;
        expect_next("armed", 1'b0, 1'b0, 2'd0, 2'd1);
        step();
        step();
        M_in = 6'd30;
        expect_next("ring", 1'b1, 1'b0, 2'd0, 2'd2);
        step();
        checks++;
        if (Alarm !== 1'b1 || state_o !== 2'd2) begin
            errors++;
            $display("FAIL ring_direct: Alarm=%b st=%0d", Alarm, state_o);
        end

        // Alarm time change during ring does not affect the event
        M_al = 6'd45;
        expect_next("alm_change", 1'b1, 1'b0, 2'd0, 2'd2);
        step();
        M_al = 6'd30;

        // Stop, then no re-ring during the same minute
        STOP_al = 1'b1;
        expect_next("stop", 1'b0, 1'b0, 2'd0, 2'd1);
        step();
        checks++;
        if (Alarm !== 1'b0 || state_o !== 2'd1) begin
            errors++;
            $display("FAIL stop_direct: Alarm=%b st=%0d", Alarm, state_o);
        end
        STOP_al = 1'b0;
        repeat (20) step();
        expect_at(cyc, "no_rering", 1'b0, 1'b0, 2'd0, 2'd1);

        // STOP held in ARMED: trigger still rings, STOP returns to ARMED next cycle
        M_in = 6'd31;
        step();
        M_in = 6'd30;
        STOP_al = 1'b1;
        expect_next("stop_armed_trig", 1'b1, 1'b0, 2'd0, 2'd2);
        step();
        expect_next("stop_after_trig", 1'b0, 1'b0, 2'd0, 2'd1);
        step();
        STOP_al = 1'b0;

        // Snooze cycle
        M_in = 6'd31;
        step();
        M_in = 6'd30;
        expect_next("ring2", 1'b1, 1'b0, 2'd0, 2'd2);
        step();
        SNOOZE = 1'b1;
        expect_next("snooze1", 1'b0, 1'b1, 2'd1, 2'd3);
        step();
        checks++;
        if (snooze_active !== 1'b1 || snooze_cnt !== 2'd1 || Alarm !== 1'b0) begin
            errors++;
            $display("FAIL snooze1_direct: Alarm=%b snz=%b cnt=%0d", Alarm, snooze_active,
                     snooze_cnt);
        end
        SNOOZE = 1'b0;
        s_cyc = cyc;
        x_cyc = tick_edge(s_cyc, 5);
        expect_at(x_cyc - 1, "snooze1_hold", 1'b0, 1'b1, 2'd1, 2'd3);
        expect_at(x_cyc, "rering1", 1'b1, 1'b0, 2'd1, 2'd2);
        wait_until(x_cyc);
        SNOOZE = 1'b1;
        expect_next("snooze2", 1'b0, 1'b1, 2'd2, 2'd3);
        step();
        SNOOZE = 1'b0;
        s_cyc = cyc;
        x_cyc = tick_edge(s_cyc, 5);
        expect_at(x_cyc, "rering2", 1'b1, 1'b0, 2'd2, 2'd2);
        wait_until(x_cyc);
        SNOOZE = 1'b1;
        expect_next("snooze_max", 1'b1, 1'b0, 2'd2, 2'd2);
        step();
        expect_next("snooze_max_hold", 1'b1, 1'b0, 2'd2, 2'd2);
        step();
        SNOOZE = 1'b0;

        // Ring timeout measured from the re-ring
        s_cyc = tick_edge(x_cyc, 8);
        expect_at(s_cyc - 1, "pre_timeout", 1'b1, 1'b0, 2'd2, 2'd2);
        expect_at(s_cyc, "timeout", 1'b0, 1'b0, 2'd0, 2'd1);
        wait_until(s_cyc);

        // Late enable within the matching minute does not ring
        AL_ON = 1'b0;
        expect_next("disarm", 1'b0, 1'b0, 2'd0, 2'd0);
        step();
        M_in = 6'd31;
        step();
        M_in = 6'd30;
        step();
        AL_ON = 1'b1;
        expect_next("late_arm", 1'b0, 1'b0, 2'd0, 2'd1);
        step();
        repeat (5) step();
        expect_at(cyc, "late_enable", 1'b0, 1'b0, 2'd0, 2'd1);

        // Disable while ringing
        M_in = 6'd31;
        step();
        M_in = 6'd30;
        expect_next("ring3", 1'b1, 1'b0, 2'd0, 2'd2);
        step();
        AL_ON = 1'b0;
        expect_next("off_ring", 1'b0, 1'b0, 2'd0, 2'd0);
        step();
        checks++;
        if (Alarm !== 1'b0 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL off_ring_direct: Alarm=%b st=%0d", Alarm, state_o);
        end
        AL_ON = 1'b1;
        step();

        // Reset mid-snooze, then a fresh match rings normally
        M_in = 6'd31;
        step();
        M_in = 6'd30;
        expect_next("ring4", 1'b1, 1'b0, 2'd0, 2'd2);
        step();
        SNOOZE = 1'b1;
        expect_next("snooze_r", 1'b0, 1'b1, 2'd1, 2'd3);
        step();
        SNOOZE = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        expect_next("rst_snooze", 1'b0, 1'b0, 2'd0, 2'd0);
        step();
        rst_cyc = cyc;
        reset = 1'b0;
        M_in = 6'd31;
        expect_next("rearm", 1'b0, 1'b0, 2'd0, 2'd1);
        step();
        M_in = 6'd30;
        expect_next("ring_after_rst", 1'b1, 1'b0, 2'd0, 2'd2);
        step();
        checks++;
        if (Alarm !== 1'b1 || state_o !== 2'd2 || snooze_cnt !== 2'd0) begin
            errors++;
            $display("FAIL ring_after_rst_direct: Alarm=%b st=%0d cnt=%0d", Alarm, state_o,
                     snooze_cnt);
        end

        repeat (10) begin
            if (sb.size() > 0) step();
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never compared, want cyc=%0d", e.name, e.cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
